// File: rtl/aud_pkg.sv
// Shared constants and types for the audio DAC FIFO block.
package aud_pkg;

  localparam logic [1:0]  AUD_ADDR_DATA     = 2'd0;
  localparam logic [1:0]  AUD_ADDR_UNDERRUN = 2'd1;
  localparam int unsigned AUD_SAMPLE_W      = 16;

  typedef enum logic [1:0] {
    SYNC,
    LEFT,
    RIGHT
  } aud_dac_state_t;

endpackage

// File: rtl/aud_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and an occupancy level.
module aud_sync_fifo #(
  parameter  int unsigned DEPTH = 64,
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  // A push into a full FIFO is only legal when a pop frees the slot that same cycle.
  assign do_pop  = pop & ~empty_q;
  assign do_push = push & (~full_q | do_pop);

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + 1'b1;
    end else if (do_pop && !do_push) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      full_q  <= (level_d == FULL_LVL);
      empty_q <= (level_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign level = level_q;

endmodule

// File: rtl/aud_dac_fifo.sv
// Avalon-MM fed PCM FIFO serialised to a codec DAC in I2S format.
// Optional underrun counter at address 1 enabled by AUD_DAC_UNDERRUN_CNT_EN.
module aud_dac_fifo
  import aud_pkg::*;
#(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned SAMPLE_W = AUD_SAMPLE_W,
  parameter int unsigned AW       = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  input  logic        read_n,
  output logic [31:0] readdata,
  input  logic        aud_bclk,
  input  logic        aud_daclrck,
  output logic        aud_dacdat,
  output logic        fifo_full,
  output logic        fifo_empty
);

  localparam int unsigned FW = 2 * SAMPLE_W;
  localparam int unsigned BW = $clog2(SAMPLE_W + 1);

  logic [2:0]          bclk_q, lr_q;
  logic                bclk_fall, lr_fall, lr_rise;
  logic                wr_en, rd_en, push, pop;
  logic [FW-1:0]       fifo_rdata;
  logic [AW:0]         level;
  aud_dac_state_t      state_q, state_d;
  logic [SAMPLE_W-1:0] right_q, right_d, shift_q, load_data;
  logic [BW-1:0]       bits_q;
  logic                dacdat_q, load, load_left;
  logic [31:0]         readdata_q, rd_mux;
  logic [15:0]         under_cnt;

  // Bit 2 is the history flop behind the two-stage synchroniser.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_q <= '0;
      lr_q   <= '0;
    end else begin
      bclk_q <= {bclk_q[1:0], aud_bclk};
      lr_q   <= {lr_q[1:0], aud_daclrck};
    end
  end

  assign bclk_fall = bclk_q[2] & ~bclk_q[1];
  assign lr_fall   = lr_q[2] & ~lr_q[1];
  assign lr_rise   = ~lr_q[2] & lr_q[1];

  assign wr_en = chipselect & ~write_n;
  assign rd_en = chipselect & ~read_n;
  assign push  = wr_en && (address == AUD_ADDR_DATA);

  aud_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   (writedata[FW-1:0]),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  always_comb begin
    state_d   = state_q;
    right_d   = right_q;
    load      = 1'b0;
    load_left = 1'b0;
    load_data = '0;
    pop       = 1'b0;
    unique case (state_q)
      SYNC: begin
        if (lr_fall) begin
          state_d   = LEFT;
          load_left = 1'b1;
        end
      end
      LEFT: begin
        if (lr_fall) begin
          load_left = 1'b1;
        end else if (lr_rise) begin
          state_d   = RIGHT;
          load      = 1'b1;
          load_data = right_q;
        end
      end
      RIGHT: begin
        if (lr_fall) begin
          state_d   = LEFT;
          load_left = 1'b1;
        end
      end
      default: state_d = SYNC;
    endcase
    // An empty FIFO at a left edge plays silence on both channels.
    if (load_left) begin
      load      = 1'b1;
      pop       = ~fifo_empty;
      load_data = fifo_empty ? '0 : fifo_rdata[FW-1 -: SAMPLE_W];
      right_d   = fifo_empty ? '0 : fifo_rdata[SAMPLE_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SYNC;
      right_q <= '0;
    end else begin
      state_q <= state_d;
      right_q <= right_d;
    end
  end

  // A load on a coincident BCLK fall suppresses that fall's output update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q  <= '0;
      bits_q   <= '0;
      dacdat_q <= 1'b0;
    end else if (load) begin
      shift_q <= load_data;
      bits_q  <= BW'(SAMPLE_W);
    end else if (bclk_fall) begin
      if (bits_q != '0) begin
        dacdat_q <= shift_q[SAMPLE_W-1];
        shift_q  <= shift_q << 1;
        bits_q   <= bits_q - 1'b1;
      end else begin
        dacdat_q <= 1'b0;
      end
    end
  end

  assign aud_dacdat = dacdat_q;

`ifdef AUD_DAC_UNDERRUN_CNT_EN
  logic        underrun;
  logic [15:0] under_cnt_q;

  assign underrun = lr_fall & fifo_empty & (state_q != SYNC);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      under_cnt_q <= '0;
    end else if (wr_en && (address == AUD_ADDR_UNDERRUN)) begin
      under_cnt_q <= '0;
    end else if (underrun && (under_cnt_q != 16'hFFFF)) begin
      under_cnt_q <= under_cnt_q + 16'd1;
    end
  end

  assign under_cnt = under_cnt_q;
`else
  assign under_cnt = '0;
`endif

  always_comb begin
    rd_mux = '0;
    if (address == AUD_ADDR_DATA) begin
      rd_mux = 32'(level);
    end else if (address == AUD_ADDR_UNDERRUN) begin
      rd_mux = {16'b0, under_cnt};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
    end else if (rd_en) begin
      readdata_q <= rd_mux;
    end
  end

  assign readdata = readdata_q;

endmodule
